// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline encodings: FSM states and hazard priority levels used by pipeline_ctrl.
// Constants only; no latency or flow control of its own.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } state_t;

    // Lower value wins; PRIO_NONE means the pipeline advances freely.
    typedef enum logic [2:0] {
        PRIO_NONE       = 3'd0,
        PRIO_FREEZE     = 3'd1,
        PRIO_REDIRECT   = 3'd2,
        PRIO_LOAD_USE   = 3'd3,
        PRIO_FETCH_MISS = 3'd4
    } prio_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
// Purely combinational, zero latency; no backpressure.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with wait FSM, dmem timeout and perf counters.
// Enables/flushes are same-cycle combinational; dmem freeze stalls every stage until ready.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout,
    output logic [1:0]       state
);
    localparam int unsigned WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          cur_state;
    state_t          next_state;
    prio_t           prio;
    logic            hazard;
    logic            freeze;
    logic [WC_W-1:0] wait_cnt;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard)
    );

    assign freeze = dmem_req & ~dmem_ready;
    assign state  = cur_state;

    // A branch held in a frozen EX waits here and fires on the first unfrozen cycle.
    always_comb begin
        if (freeze)                prio = PRIO_FREEZE;
        else if (ex_branch_taken)  prio = PRIO_REDIRECT;
        else if (hazard)           prio = PRIO_LOAD_USE;
        else if (!imem_ready)      prio = PRIO_FETCH_MISS;
        else                       prio = PRIO_NONE;
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_flush    = 1'b0;
        next_state  = ST_RUN;
        case (prio)
            PRIO_FREEZE: begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                id_ex_en   = 1'b0;
                ex_mem_en  = 1'b0;
                mem_wb_en  = 1'b0;
                next_state = ST_DWAIT;
            end
            PRIO_REDIRECT: begin
                if_id_flush = 1'b1;
                id_flush    = 1'b1;
            end
            PRIO_LOAD_USE: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_flush = 1'b1;
            end
            PRIO_FETCH_MISS: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                next_state  = ST_IWAIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= ST_RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == ST_DWAIT && freeze) begin
                if (wait_cnt != WC_W'(TIMEOUT))
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt == WC_W'(TIMEOUT))
                mem_timeout <= 1'b1;
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if ((prio == PRIO_REDIRECT) && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;
    localparam int T = 4;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b1;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_flush, mem_timeout;
    logic [W-1:0] stall_cycles, flush_events;
    logic [1:0] state;

    pipeline_ctrl #(.TIMEOUT(T), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_flush(id_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst_n;
        logic [4:0] rs1, rs2;
        logic u1, u2;
        logic [4:0] rd;
        logic mr, br, imr, dreq, drdy;
    } stim_t;

    // {pc,if_id,id_ex,ex_mem,mem_wb, if_id_flush,id_flush, state, stall, flush, timeout}
    typedef logic [7+2+W+W+1-1:0] obs_t;

    obs_t sb[$];
    int tests = 0, fails = 0;
    bit drv_done = 1'b0;

    // Reference model state: wait-cycle bookkeeping and counters as plain integers.
    int m_state = 0, m_wait = 0, m_stall = 0, m_flush = 0;
    bit m_to = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.imr = 1'b1;
        s.drdy = 1'b1;
        return s;
    endfunction

    // 1 freeze, 2 redirect, 3 load-use, 4 fetch miss, 0 free-running.
    function automatic int level(stim_t s);
        bit lu;
        lu = s.mr && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (s.dreq && !s.drdy) return 1;
        if (s.br) return 2;
        if (lu) return 3;
        if (!s.imr) return 4;
        return 0;
    endfunction

    function automatic obs_t expect_of(stim_t s);
        logic [6:0] ctl;
        case (level(s))
            1:       ctl = 7'b00000_00;
            2:       ctl = 7'b11111_11;
            3:       ctl = 7'b00111_01;
            4:       ctl = 7'b01111_10;
            default: ctl = 7'b11111_00;
        endcase
        return {ctl, 2'(m_state), W'(m_stall), W'(m_flush), m_to};
    endfunction

    task automatic model_edge(stim_t s);
        int lv;
        lv = level(s);
        if (m_wait == T) m_to = 1'b1;
        if (m_state == 1 && lv == 1) m_wait = (m_wait < T) ? m_wait + 1 : T;
        else m_wait = 0;
        if (lv == 1 || lv == 3 || lv == 4) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (lv == 2) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        m_state = (lv == 1) ? 1 : (lv == 4) ? 2 : 0;
    endtask

    task automatic step(stim_t s);
        @(posedge clk);
        #1;
        rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
        ex_rd = s.rd; ex_mem_read = s.mr; ex_branch_taken = s.br; imem_ready = s.imr;
        dmem_req = s.dreq; dmem_ready = s.drdy;
        if (!s.rst_n) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
        end
        sb.push_back(expect_of(s));
        if (s.rst_n) model_edge(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        step(s);
    endtask

    // Monitor: one comparison per observed cycle, against the oldest expectation.
    initial begin
        obs_t got, exp_v;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_flush,
                       state, stall_cycles, flush_events, mem_timeout};
                tests++;
                if (got !== exp_v) begin
                    fails++;
                    $display("FAIL cycle_check t=%0t got=%h expected=%h", $time, got, exp_v);
                end
            end
        end
    end

    initial begin
        stim_t s;
        do_reset();
        do_reset();

        // Load-use on rs1, then same with x0 destination.
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        step(s);
        step(idle());
        s.rd = 0; s.rs1 = 0;
        step(s);
        step(idle());

        // Freeze with a pending branch, then release into the redirect.
        do_reset();
        s = idle(); s.dreq = 1; s.drdy = 0; s.br = 1;
        repeat (3) step(s);
        s.drdy = 1;
        step(s);
        step(idle());

        // Long freeze trips the timeout, which stays sticky until reset.
        do_reset();
        s = idle(); s.dreq = 1; s.drdy = 0;
        repeat (8) step(s);
        repeat (3) step(idle());
        do_reset();
        step(idle());

        // Fetch miss coincident with load-use: load-use wins, state stays RUN.
        s = idle(); s.imr = 0; s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
        step(s);
        step(idle());

        // Stall counter saturation via sustained fetch misses.
        do_reset();
        s = idle(); s.imr = 0;
        repeat (20) step(s);
        step(idle());

        // Randomized traffic with occasional resets.
        repeat (600) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.mr  = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 3) == 0);
            s.imr = ($urandom_range(0, 4) != 0);
            s.dreq = ($urandom_range(0, 2) == 0);
            s.drdy = ($urandom_range(0, 3) == 0);
            step(s);
        end

        repeat (3) @(posedge clk);
        drv_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        #2;
        tests++;
        if (!drv_done || sb.size() != 0) begin
            fails++;
            $display("FAIL drain done=%0d pending=%0d required_pending=0", drv_done, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive data-memory wait cycles before error.
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_rd  input  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch or jump (redirect PC).
REQ-010 imem_ready  input  1  instruction fetch data valid this cycle.
REQ-011 dmem_req, dmem_ready  input  1 each  MEM-stage access pending / completing this cycle.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register load enables.
REQ-013 if_id_flush  output  1  load bubble into IF/ID.
REQ-014 id_flush  output  1  drives the decoder flush input, forcing a control bubble into ID/EX.
REQ-015 stall_cycles, flush_events  output  CNT_W each  saturating performance counters.
REQ-016 mem_timeout  output  1  sticky data-memory timeout error.
REQ-017 state  output  2  current FSM state, for debug.

Function
REQ-018 Enables and flushes SHALL be combinational from inputs and state, same-cycle, zero latency.
REQ-019 Priority 1 freeze (dmem_req & !dmem_ready): all five enables 0, both flushes 0.
REQ-020 Priority 2 redirect (ex_branch_taken, no freeze): all enables 1, if_id_flush=1, id_flush=1.
REQ-021 Priority 3 load-use (ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))): pc_en=0, if_id_en=0, id_flush=1, other enables 1.
REQ-022 Priority 4 fetch miss (!imem_ready): pc_en=0, if_id_en=1 with if_id_flush=1, other enables 1.
REQ-023 Otherwise all enables 1, flushes 0.
REQ-024 Redirect SHALL override load-use and fetch miss in the same cycle; a redirect coinciding with freeze takes effect on the first unfrozen cycle (ex_branch_taken held by frozen EX).
REQ-025 States RUN=0, DWAIT=1, IWAIT=2; next state chosen by active priority: freeze->DWAIT, fetch miss (priority 4 active)->IWAIT, else RUN.
REQ-026 wait_cnt (internal) SHALL increment each cycle in DWAIT with freeze still active, clear on any other cycle; saturates at TIMEOUT.
REQ-027 When wait_cnt reaches TIMEOUT, mem_timeout SHALL set on the next edge and hold until reset; the pipeline stays frozen.
REQ-028 stall_cycles SHALL increment on each edge where pc_en was 0; flush_events on each edge where priority 2 was active; both saturate at all-ones.

Reset
REQ-029 On rst_n low: state=RUN, wait_cnt=0, counters=0, mem_timeout=0, asynchronously.
REQ-030 Reset mid-stall SHALL abandon DWAIT/IWAIT immediately; outputs then follow REQ-019..023 from RUN.

Structure
REQ-031 State encodings and priority constants SHALL live in the shared CPU package alongside decoder control encodings.
REQ-032 Hazard-compare logic MAY be one sub-module, load_use_detect; counters and FSM stay in pipeline_ctrl.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_en=0, if_id_en=0, id_flush=1 one cycle; stall_cycles +1.
REQ-034 Same as REQ-033 with ex_rd=0 -> no stall, all enables 1.
REQ-035 dmem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> enables 0, state=DWAIT, 3 cycles; dmem_ready=1 -> redirect flush, flush_events=1.
REQ-036 TIMEOUT=4, dmem_ready held 0 -> mem_timeout rises after 4 DWAIT cycles, stays 1 after dmem_ready=1 until rst_n pulse.
REQ-037 imem_ready=0 plus load-use hazard -> load-use response (pc_en=0, id_flush=1), state=RUN.
REQ-038 Force stall_cycles to all-ones (CNT_W=4, 16 stall cycles) -> stays 15.
